// File: rtl/ps2_key_decoder_pkg.sv
// Shared encodings and constants for the PS/2 receiver and key decoder.
// Frame FSM states, prefix bytes and the default set-2 key codes.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_PAR  = 2'd2,
        RX_STOP = 2'd3
    } rx_state_e;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] DEF_CODE_JUMP  = 8'h24;
    localparam logic [7:0] DEF_CODE_LEFT  = 8'h1C;
    localparam logic [7:0] DEF_CODE_RIGHT = 8'h23;

    // Odd parity holds when data plus parity carry an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchroniser, clock filter, frame FSM, timeout.
// Emits one registered strobe per good frame or per errored frame.
import ps2_key_decoder_pkg::*;

module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    scan_q, scan_d;

    // Two-flop synchronisers; lines idle high so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        sample = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                sample = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Frame FSM and timeout, advancing on filtered falling edges.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        tmo_d        = '0;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        scan_d       = scan_q;
        if (sample) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = RX_PAR;
                end
                RX_PAR: begin
                    par_d   = dat_s2_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (odd_parity_ok(shreg_q, par_q) && dat_s2_q) begin
                        code_valid_d = 1'b1;
                        scan_d       = shreg_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d     = RX_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Filter, FSM and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            scan_q       <= '0;
        end else begin
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            scan_q       <= scan_d;
        end
    end

    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign scan_code  = scan_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame receiver plus make/break key decoder.
// Holds jump/left/right levels and a rise pulse for the jump key.
import ps2_key_decoder_pkg::*;

module ps2_key_decoder #(
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] CODE_JUMP   = DEF_CODE_JUMP,
    parameter logic [7:0] CODE_LEFT   = DEF_CODE_LEFT,
    parameter logic [7:0] CODE_RIGHT  = DEF_CODE_RIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       e_key,
    output logic       e_key_rise,
    output logic       left_key,
    output logic       right_key,
    output logic       code_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic brk_q, brk_d;
    logic ext_q, ext_d;
    logic e_q, e_d;
    logic rise_q, rise_d;
    logic left_q, left_d;
    logic right_q, right_d;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_valid(code_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    // Prefix bytes arm flags; a plain byte applies them, then clears them.
    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        e_d     = e_q;
        left_d  = left_q;
        right_d = right_q;
        if (code_valid) begin
            unique case (1'b1)
                (scan_code == PS2_BREAK): brk_d = 1'b1;
                (scan_code == PS2_EXT):   ext_d = 1'b1;
                default: begin
                    if (!ext_q) begin
                        if (scan_code == CODE_JUMP)
                            e_d = !brk_q;
                        if (scan_code == CODE_LEFT)
                            left_d = !brk_q;
                        if (scan_code == CODE_RIGHT)
                            right_d = !brk_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end
        rise_d = e_d & ~e_q;
    end

    // Key levels, prefix flags and the jump rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            e_q     <= 1'b0;
            rise_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            e_q     <= e_d;
            rise_q  <= rise_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign e_key      = e_q;
    assign e_key_rise = rise_q;
    assign left_key   = left_q;
    assign right_key  = right_q;

endmodule
